// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter : two-port arbiter in front of a single DataMemoryRAM.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin ties, else fixed prio).
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_we_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  output logic                  resp0_valid_o,
  output logic [DATA_WIDTH-1:0] resp0_rdata_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_we_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  output logic                  resp1_valid_o,
  output logic [DATA_WIDTH-1:0] resp1_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_data_in_o,
  input  logic [DATA_WIDTH-1:0] mem_data_out_i
);

  logic w_prefer0;
  logic w_grant0;
  logic w_grant1;
  logic rsp_vld_q, rsp_vld_d;
  logic rsp_port_q, rsp_port_d;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_q = 1 means port 1 was granted most recently, so port 0 wins a tie.
  logic last_grant_q, last_grant_d;
  assign w_prefer0 = last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (w_grant1)      last_grant_d = 1'b1;
    else if (w_grant0) last_grant_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign w_prefer0 = 1'b1;
`endif

  assign w_grant0 = ~rst & req0_valid_i & (~req1_valid_i | w_prefer0);
  assign w_grant1 = ~rst & req1_valid_i & ~w_grant0;

  assign req0_ready_o = w_grant0;
  assign req1_ready_o = w_grant1;

  always_comb begin
    mem_addr_o    = '0;
    mem_we_o      = 1'b0;
    mem_data_in_o = '0;
    if (w_grant0) begin
      mem_addr_o    = req0_addr_i;
      mem_we_o      = req0_we_i;
      mem_data_in_o = req0_wdata_i;
    end else if (w_grant1) begin
      mem_addr_o    = req1_addr_i;
      mem_we_o      = req1_we_i;
      mem_data_in_o = req1_wdata_i;
    end
  end

  always_comb begin
    rsp_vld_d  = (w_grant0 & ~req0_we_i) | (w_grant1 & ~req1_we_i);
    rsp_port_d = w_grant1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q  <= 1'b0;
      rsp_port_q <= 1'b0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_port_q <= rsp_port_d;
    end
  end

  // Gating with rst drops a read that was granted just before reset asserted.
  assign resp0_valid_o = rsp_vld_q & ~rsp_port_q & ~rst;
  assign resp1_valid_o = rsp_vld_q &  rsp_port_q & ~rst;
  assign resp0_rdata_o = mem_data_out_i;
  assign resp1_rdata_o = mem_data_out_i;

endmodule

`default_nettype wire
